// File: rtl/pwm_line_loader.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_line_loader
//  Purpose  : FIFO-buffered byte feeder. Replays STAGE-byte bursts framed by
//             a start pulse into the PWM data-shift input.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_line_loader #(
   parameter int STAGE      = 8,
   parameter int DWIDTH     = 8,
   parameter int DEPTH      = 32,
   parameter int GAP_CYCLES = 2
) (
   input  logic                     clkfordata,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DWIDTH-1:0]        in_data,
   input  logic                     pwm_ready,
   output logic                     start,
   output logic [DWIDTH-1:0]        data,
   output logic                     burst_active,
   output logic                     line_done,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              line_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int IW = (STAGE > 1) ? $clog2(STAGE) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [LW-1:0] LVL_STAGE = LW'(STAGE);
   localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);
   localparam logic [IW-1:0] IDX_LAST  = IW'(STAGE - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t              state;
   logic [IW-1:0]       idx;
   logic [GW-1:0]       gap_cnt;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [DWIDTH-1:0]   mem [DEPTH];

   logic                launch;
   logic                push;
   logic                pop;

   // Launch decision uses the registered level, so a byte written on the
   // same edge cannot complete a line early.
   assign launch   = (state == IDLE) && (level >= LVL_STAGE) && pwm_ready;
   assign pop      = launch || ((state == BURST) && (idx != IDX_LAST));
   assign in_ready = (level != LVL_DEPTH);
   assign push     = in_valid && in_ready;

   always_ff @(posedge clkfordata) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clkfordata or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
      end
   end

   // idx is the index of the byte currently on data.
   always_ff @(posedge clkfordata or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         gap_cnt      <= '0;
         start        <= 1'b0;
         data         <= '0;
         burst_active <= 1'b0;
         line_done    <= 1'b0;
         line_count   <= '0;
      end else begin
         start     <= 1'b0;
         line_done <= 1'b0;
         case (state)
            IDLE: begin
               data         <= '0;
               burst_active <= 1'b0;
               if (launch) begin
                  state        <= BURST;
                  start        <= 1'b1;
                  data         <= mem[rd_ptr];
                  burst_active <= 1'b1;
                  idx          <= '0;
               end
            end
            BURST: begin
               if (idx == IDX_LAST) begin
                  data         <= '0;
                  burst_active <= 1'b0;
                  line_done    <= 1'b1;
                  line_count   <= line_count + 16'd1;
                  gap_cnt      <= '0;
                  state        <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end else begin
                  data <= mem[rd_ptr];
                  idx  <= idx + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               data         <= '0;
               burst_active <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_line_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_line_loader
//  Purpose  : Directed self-checking bench for pwm_line_loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_line_loader;

   logic        clkfordata = 1'b0;
   logic        rst_n      = 1'b0;
   logic        in_valid   = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data    = 8'h00;
   logic        pwm_ready  = 1'b0;
   logic        start;
   logic [7:0]  data;
   logic        burst_active;
   logic        line_done;
   logic [5:0]  level;
   logic [15:0] line_count;

   int total = 0;
   int bad   = 0;

   pwm_line_loader #(
      .STAGE      (8),
      .DWIDTH     (8),
      .DEPTH      (32),
      .GAP_CYCLES (2)
   ) dut (
      .clkfordata   (clkfordata),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .pwm_ready    (pwm_ready),
      .start        (start),
      .data         (data),
      .burst_active (burst_active),
      .line_done    (line_done),
      .level        (level),
      .line_count   (line_count)
   );

   always #5 clkfordata = ~clkfordata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clkfordata);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      pwm_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Pushes n consecutive bytes from base; assumes the FIFO has room.
   task automatic push_n(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         in_data  = base + 8'(i);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_start(output int cnt);
      cnt = 0;
      while (!start && cnt < 100) begin
         tick();
         cnt++;
      end
      check("start_seen", start, 1);
   endtask

   // Entered on the cycle where start is high; leaves on the line_done cycle.
   task automatic check_line(input logic [7:0] base);
      check("start_first", start, 1);
      check("data_first", data, base);
      check("active_first", burst_active, 1);
      for (int j = 1; j < 8; j++) begin
         tick();
         check("start_low", start, 0);
         check("data_seq", data, base + 8'(j));
         check("active_mid", burst_active, 1);
      end
      tick();
      check("line_done", line_done, 1);
      check("active_off", burst_active, 0);
      check("data_off", data, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int pushed;
      logic acc;

      // 1. Reset holds state while in_valid is asserted.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (3) tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_level", level, 0);
      check("rst_start", start, 0);
      check("rst_data", data, 0);
      check("rst_line_count", line_count, 0);
      rst_n = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rst_release_accept", level, 1);

      // 2. Single line with one-cycle latency after the 8th write.
      do_reset();
      pwm_ready = 1'b1;
      push_n(8'h01, 8);
      check("single_pre_start", start, 0);
      check("single_level", level, 8);
      wait_start(cnt);
      check("single_latency", cnt, 1);
      check_line(8'h01);
      check("single_count", line_count, 1);
      check("single_level_end", level, 0);

      // 3. Gating by pwm_ready, then two lines with a three-cycle idle gap.
      do_reset();
      push_n(8'h10, 16);
      repeat (3) tick();
      check("gate_no_start", start, 0);
      check("gate_level", level, 16);
      pwm_ready = 1'b1;
      wait_start(cnt);
      check("gate_latency", cnt, 1);
      check_line(8'h10);
      tick();
      check("gap_idle2", start, 0);
      tick();
      check("gap_idle3", start, 0);
      check("gap_idle3_active", burst_active, 0);
      tick();
      check_line(8'h18);
      check("gate_count", line_count, 2);
      check("gate_level_end", level, 0);

      // 4. Full FIFO stalls, then drains in order while the rest streams in.
      do_reset();
      push_n(8'h40, 32);
      in_valid = 1'b1;
      in_data  = 8'h60;
      repeat (3) tick();
      check("full_ready", in_ready, 0);
      check("full_level", level, 32);
      pwm_ready = 1'b1;
      pushed = 32;
      fork
         begin
            for (int c = 0; c < 300 && pushed < 40; c++) begin
               in_data  = 8'h40 + 8'(pushed);
               in_valid = 1'b1;
               acc      = in_ready;
               tick();
               if (acc) pushed++;
            end
            in_valid = 1'b0;
         end
         begin
            for (int l = 0; l < 5; l++) begin
               wait_start(cnt);
               check_line(8'h40 + 8'(8 * l));
            end
         end
      join
      check("full_all_pushed", pushed, 40);
      check("full_count", line_count, 5);
      check("full_level_end", level, 0);

      // 5. A partial line waits until complete.
      do_reset();
      pwm_ready = 1'b1;
      push_n(8'h60, 5);
      repeat (4) tick();
      check("partial_no_start", start, 0);
      check("partial_level", level, 5);
      push_n(8'h65, 3);
      wait_start(cnt);
      check("partial_latency", cnt, 1);
      check_line(8'h60);

      // 6. Asynchronous reset mid-burst, then a clean line.
      do_reset();
      pwm_ready = 1'b1;
      push_n(8'h70, 8);
      wait_start(cnt);
      repeat (3) tick();
      check("midrst_idx3", data, 8'h73);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_start", start, 0);
      check("midrst_data", data, 0);
      check("midrst_active", burst_active, 0);
      check("midrst_level", level, 0);
      tick();
      rst_n = 1'b1;
      tick();
      push_n(8'h80, 8);
      wait_start(cnt);
      check("midrst_latency", cnt, 1);
      check_line(8'h80);
      check("midrst_count", line_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
